// File: rtl/code_buffer.sv
// Keypad code datapath: captures digit presses during an entry window and
// compares them against the programming code, the live user code or a pending candidate.
module code_buffer #(
    parameter int                     MAX_LEN        = 8,
    parameter int                     MIN_LEN        = 4,
    parameter int                     PC_LEN         = 6,
    parameter logic [MAX_LEN*4-1:0]   PC_CODE        = 32'h0065_4321,
    parameter logic [MAX_LEN*4-1:0]   UC_DEFAULT     = 32'h0000_4321,
    parameter int                     UC_DEFAULT_LEN = 4
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       read_input,
    input  logic       store,
    input  logic [1:0] compareType,
    output logic       correct_input,
    output logic       validLength,
    output logic       validLengthPC,
    output logic       data_ready,
    output logic [3:0] entry_len
);

    localparam int         W         = MAX_LEN * 4;
    localparam logic [3:0] MAX_LEN4  = 4'(MAX_LEN);
    localparam logic [3:0] MIN_LEN4  = 4'(MIN_LEN);
    localparam logic [3:0] PC_LEN4   = 4'(PC_LEN);
    localparam logic [3:0] UC_LEN4   = 4'(UC_DEFAULT_LEN);

    typedef enum logic [1:0] {
        COMPAREPC = 2'b00,
        COMPAREUC = 2'b01,
        MATCHUC   = 2'b10,
        STOREUC   = 2'b11
    } cmp_type_e;

    cmp_type_e      cmpType;
    logic           press;
    logic           readRise;

    logic           prevBstate_q, readInPrev_q, dataReady_q;
    logic [W-1:0]   entry_q, entry_d;
    logic [3:0]     entryLen_q, entryLen_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   cand_q, cand_d;
    logic [3:0]     candLen_q, candLen_d;
    logic           candOvf_q, candOvf_d;
    logic [W-1:0]   uc_q, uc_d;
    logic [3:0]     ucLen_q, ucLen_d;

    assign cmpType  = cmp_type_e'(compareType);
    assign press    = prevBstate_q & ~bstate;
    assign readRise = read_input & ~readInPrev_q;

    // Opening a new entry window takes priority over any press in the same cycle.
    always_comb begin
        entry_d    = entry_q;
        entryLen_d = entryLen_q;
        ovf_d      = ovf_q;
        cand_d     = cand_q;
        candLen_d  = candLen_q;
        candOvf_d  = candOvf_q;
        uc_d       = uc_q;
        ucLen_d    = ucLen_q;

        if (readRise) begin
            entry_d    = '0;
            entryLen_d = '0;
            ovf_d      = 1'b0;
        end else if (press && read_input) begin
            if (button <= 4'd6) begin
                if (entryLen_q < MAX_LEN4) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (entryLen_q == 4'(i)) begin
                            entry_d[i*4 +: 4] = button;
                        end
                    end
                    entryLen_d = entryLen_q + 4'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (button == 4'd8 && cmpType == STOREUC) begin
                cand_d     = entry_q;
                candLen_d  = entryLen_q;
                candOvf_d  = ovf_q;
                entry_d    = '0;
                entryLen_d = '0;
                ovf_d      = 1'b0;
            end
        end

        if (store && !candOvf_q && candLen_q >= MIN_LEN4) begin
            uc_d    = cand_q;
            ucLen_d = candLen_q;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            prevBstate_q <= 1'b0;
            readInPrev_q <= 1'b0;
            dataReady_q  <= 1'b0;
            entry_q      <= '0;
            entryLen_q   <= '0;
            ovf_q        <= 1'b0;
            cand_q       <= '0;
            candLen_q    <= '0;
            candOvf_q    <= 1'b1;
            uc_q         <= UC_DEFAULT;
            ucLen_q      <= UC_LEN4;
        end else begin
            prevBstate_q <= bstate;
            readInPrev_q <= read_input;
            dataReady_q  <= ~read_input;
            entry_q      <= entry_d;
            entryLen_q   <= entryLen_d;
            ovf_q        <= ovf_d;
            cand_q       <= cand_d;
            candLen_q    <= candLen_d;
            candOvf_q    <= candOvf_d;
            uc_q         <= uc_d;
            ucLen_q      <= ucLen_d;
        end
    end

    // Full-vector equality is safe because unused digit slots are always zero.
    always_comb begin
        correct_input = 1'b0;
        unique case (cmpType)
            COMPAREPC: correct_input = (entry_q == PC_CODE) && (entryLen_q == PC_LEN4) && !ovf_q;
            COMPAREUC: correct_input = (entry_q == uc_q) && (entryLen_q == ucLen_q) && !ovf_q;
            MATCHUC:   correct_input = (entry_q == cand_q) && (entryLen_q == candLen_q) && !ovf_q
                                       && !candOvf_q && (candLen_q >= MIN_LEN4);
            STOREUC:   correct_input = 1'b0;
            default:   correct_input = 1'b0;
        endcase
    end

    assign validLength   = !ovf_q && (entryLen_q >= MIN_LEN4) && (entryLen_q <= MAX_LEN4);
    assign validLengthPC = !ovf_q && (entryLen_q == PC_LEN4);
    assign data_ready    = dataReady_q;
    assign entry_len     = entryLen_q;

endmodule

// File: tb/tb_code_buffer.sv
// Directed bench for code_buffer: PC/UC checks, overflow, reprogramming,
// masking of ignored presses and reset mid-entry.
module tb_code_buffer;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] button = 4'd0;
    logic       bstate = 1'b0;
    logic       read_input = 1'b0;
    logic       store = 1'b0;
    logic [1:0] compareType = 2'b00;
    logic       correct_input, validLength, validLengthPC, data_ready;
    logic [3:0] entry_len;

    int passCount = 0;
    int checkCount = 0;

    code_buffer dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .button        (button),
        .bstate        (bstate),
        .read_input    (read_input),
        .store         (store),
        .compareType   (compareType),
        .correct_input (correct_input),
        .validLength   (validLength),
        .validLengthPC (validLengthPC),
        .data_ready    (data_ready),
        .entry_len     (entry_len)
    );

    always #5 hwclk = ~hwclk;

    // Hold the key for one cycle, release it, then wait one cycle so the digit is visible.
    task automatic pressKey(input logic [3:0] k);
        @(negedge hwclk);
        button = k;
        bstate = 1'b1;
        @(negedge hwclk);
        bstate = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic startEntry();
        @(negedge hwclk);
        read_input = 1'b1;
        @(negedge hwclk);
    endtask

    task automatic endEntry();
        @(negedge hwclk);
        read_input = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic pulseStore(input int cycles);
        @(negedge hwclk);
        store = 1'b1;
        repeat (cycles) @(negedge hwclk);
        store = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge hwclk);
        checkCount++;
        if (entry_len !== 4'd0) $display("[TB] FAIL reset_entry_len: got %0d expected 0", entry_len);
        else passCount++;
        checkCount++;
        if (validLength !== 1'b0) $display("[TB] FAIL reset_validLength: got %b expected 0", validLength);
        else passCount++;
        checkCount++;
        if (validLengthPC !== 1'b0) $display("[TB] FAIL reset_validLengthPC: got %b expected 0", validLengthPC);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL reset_correct: got %b expected 0", correct_input);
        else passCount++;
        checkCount++;
        if (data_ready !== 1'b0) $display("[TB] FAIL reset_data_ready: got %b expected 0", data_ready);
        else passCount++;
        @(negedge hwclk);
        reset = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic test_pc_accept();
        compareType = 2'b00;
        startEntry();
        for (int d = 1; d <= 6; d++) pressKey(4'(d));
        checkCount++;
        if (validLengthPC !== 1'b1) $display("[TB] FAIL pc_validLengthPC: got %b expected 1", validLengthPC);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL pc_correct: got %b expected 1", correct_input);
        else passCount++;
        @(negedge hwclk);
        read_input = 1'b0;
        #1;
        checkCount++;
        if (data_ready !== 1'b0) $display("[TB] FAIL pc_data_ready_fall_cycle: got %b expected 0", data_ready);
        else passCount++;
        @(negedge hwclk);
        checkCount++;
        if (data_ready !== 1'b1) $display("[TB] FAIL pc_data_ready_after: got %b expected 1", data_ready);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL pc_correct_held: got %b expected 1", correct_input);
        else passCount++;
    endtask

    task automatic test_default_uc();
        compareType = 2'b01;
        startEntry();
        checkCount++;
        if (data_ready !== 1'b0) $display("[TB] FAIL uc_data_ready_low: got %b expected 0", data_ready);
        else passCount++;
        for (int d = 1; d <= 4; d++) pressKey(4'(d));
        checkCount++;
        if (validLength !== 1'b1) $display("[TB] FAIL uc4_validLength: got %b expected 1", validLength);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL uc4_correct: got %b expected 1", correct_input);
        else passCount++;
        endEntry();
        startEntry();
        for (int d = 1; d <= 3; d++) pressKey(4'(d));
        checkCount++;
        if (validLength !== 1'b0) $display("[TB] FAIL uc3_validLength: got %b expected 0", validLength);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL uc3_correct: got %b expected 0", correct_input);
        else passCount++;
        endEntry();
    endtask

    task automatic test_overflow();
        compareType = 2'b01;
        startEntry();
        for (int d = 1; d <= 8; d++) pressKey(4'(d % 7));
        checkCount++;
        if (validLength !== 1'b1) $display("[TB] FAIL ovf_len8_validLength: got %b expected 1", validLength);
        else passCount++;
        pressKey(4'd1);
        checkCount++;
        if (entry_len !== 4'd8) $display("[TB] FAIL ovf_entry_len: got %0d expected 8", entry_len);
        else passCount++;
        checkCount++;
        if (validLength !== 1'b0) $display("[TB] FAIL ovf_validLength: got %b expected 0", validLength);
        else passCount++;
        for (int ct = 0; ct < 4; ct++) begin
            compareType = 2'(ct);
            #1;
            checkCount++;
            if (correct_input !== 1'b0) $display("[TB] FAIL ovf_correct_ct%0d: got %b expected 0", ct, correct_input);
            else passCount++;
        end
        endEntry();
    endtask

    task automatic test_reprogram();
        compareType = 2'b11;
        startEntry();
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (entry_len !== 4'd5) $display("[TB] FAIL store_pre_len: got %0d expected 5", entry_len);
        else passCount++;
        pressKey(4'd8);
        checkCount++;
        if (entry_len !== 4'd0) $display("[TB] FAIL store_key8_len: got %0d expected 0", entry_len);
        else passCount++;
        compareType = 2'b10;
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL match_correct: got %b expected 1", correct_input);
        else passCount++;
        endEntry();
        pulseStore(5);
        compareType = 2'b01;
        startEntry();
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL newuc_correct: got %b expected 1", correct_input);
        else passCount++;
        endEntry();
        startEntry();
        for (int d = 1; d <= 4; d++) pressKey(4'(d));
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL olduc_rejected: got %b expected 0", correct_input);
        else passCount++;
        endEntry();
    endtask

    task automatic test_mismatch();
        compareType = 2'b11;
        startEntry();
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        pressKey(4'd8);
        compareType = 2'b10;
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd1);
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL mismatch_correct: got %b expected 0", correct_input);
        else passCount++;
        endEntry();
        compareType = 2'b11;
        startEntry();
        pressKey(4'd1); pressKey(4'd2); pressKey(4'd3);
        pressKey(4'd8);
        compareType = 2'b10;
        pressKey(4'd1); pressKey(4'd2); pressKey(4'd3);
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL short_cand_match: got %b expected 0", correct_input);
        else passCount++;
        endEntry();
        pulseStore(3);
        compareType = 2'b01;
        startEntry();
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL uc_unchanged: got %b expected 1", correct_input);
        else passCount++;
        endEntry();
    endtask

    task automatic test_masking_and_reset();
        pressKey(4'd3);
        checkCount++;
        if (entry_len !== 4'd5) $display("[TB] FAIL closed_press_len: got %0d expected 5", entry_len);
        else passCount++;
        // Press released in the same cycle read_input rises: the clear wins.
        @(negedge hwclk);
        button = 4'd5;
        bstate = 1'b1;
        @(negedge hwclk);
        read_input = 1'b1;
        bstate = 1'b0;
        @(negedge hwclk);
        checkCount++;
        if (entry_len !== 4'd0) $display("[TB] FAIL rise_press_len: got %0d expected 0", entry_len);
        else passCount++;
        compareType = 2'b01;
        pressKey(4'd6); pressKey(4'd5);
        pressKey(4'd12); pressKey(4'd7); pressKey(4'd9);
        checkCount++;
        if (entry_len !== 4'd2) $display("[TB] FAIL ignored_keys_len: got %0d expected 2", entry_len);
        else passCount++;
        pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL ignored_keys_correct: got %b expected 1", correct_input);
        else passCount++;
        @(negedge hwclk);
        reset = 1'b1;
        @(negedge hwclk);
        checkCount++;
        if (entry_len !== 4'd0) $display("[TB] FAIL midreset_len: got %0d expected 0", entry_len);
        else passCount++;
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL midreset_correct: got %b expected 0", correct_input);
        else passCount++;
        reset = 1'b0;
        @(negedge hwclk);
        for (int d = 1; d <= 4; d++) pressKey(4'(d));
        checkCount++;
        if (correct_input !== 1'b1) $display("[TB] FAIL default_restored: got %b expected 1", correct_input);
        else passCount++;
        endEntry();
        startEntry();
        pressKey(4'd6); pressKey(4'd5); pressKey(4'd4); pressKey(4'd3); pressKey(4'd2);
        checkCount++;
        if (correct_input !== 1'b0) $display("[TB] FAIL reprogram_lost: got %b expected 0", correct_input);
        else passCount++;
        endEntry();
    endtask

    initial begin
        test_reset();
        test_pc_accept();
        test_default_uc();
        test_overflow();
        test_reprogram();
        test_mismatch();
        test_masking_and_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/code_buffer.md
# code_buffer

Keypad code datapath beside the lock `controller`. It captures digit presses while `read_input` is high and holds the live user code (UC) and the fixed programming code (PC). It returns `correct_input`, `validLength`, `validLengthPC` and `data_ready` according to `compareType`. On `store` it commits a newly entered UC.

## Interface
- `MAX_LEN`, 8: maximum digits per entry (≤15).
- `MIN_LEN`, 4: minimum digits for a valid UC.
- `PC_LEN`, 6: programming-code length.
- `PC_CODE`, 32'h0065_4321: PC digits; digit i at bits [4i+3:4i], digit 0 is entered first. Unused slots are 0.
- `UC_DEFAULT`, 32'h0000_4321: UC loaded at reset.
- `UC_DEFAULT_LEN`, 4: UC length at reset.

Ports:
- `hwclk` in 1: system clock. One clock domain.
- `reset` in 1: reset, asynchronous and active-high.
- `button` in 4: keypad value. 0–6 are digits, 7 is cancel, 8 is program/enter, 9 is lock/enter, 10–15 are ignored.
- `bstate` in 1: button-held level. A press event is its falling edge.
- `read_input` in 1: entry window enable from `controller`.
- `store` in 1: commit candidate to UC. May be held for many cycles.
- `compareType` in 2: 00 COMPAREPC, 01 COMPAREUC, 10 MATCHUC, 11 STOREUC.
- `correct_input` out 1: comparison result (combinational).
- `validLength` out 1: entry length is valid for a UC (combinational).
- `validLengthPC` out 1: entry length equals `PC_LEN` (combinational).
- `data_ready` out 1: entry closed; result is stable (registered).
- `entry_len` out 4: current digit count (debug).

## Operation
- **Press event.** `prev_bstate` is a register loaded from `bstate` each cycle. `press = prev_bstate & ~bstate`, evaluated in the same cycle, using the same detection as `controller`.
- **Entry buffer.** `entry[MAX_LEN*4-1:0]`, `entry_len`, and an `ovf` flag.
- **Clearing.** On a rising edge of `read_input`, clear `entry` to 0, `entry_len` to 0 and `ovf` to 0. The rise is detected with a registered copy of `read_input`.
- **Digit press** (`press` and `read_input` and `button` ≤ 6):
  - If `entry_len < MAX_LEN`: write the digit into slot `entry_len`, then `entry_len`+1.
  - Otherwise set `ovf`; the buffer is unchanged.
- **Presses ignored entirely:** any press while `read_input` = 0, and any `button` value of 10–15.
- **Key 8 with STOREUC** (`press` and `read_input` and `button` = 8 and `compareType` = STOREUC):
  - Copy `cand` ← `entry`, `cand_len` ← `entry_len`, `cand_ovf` ← `ovf`.
  - In the same edge, clear `entry`, `entry_len` and `ovf` for the confirmation entry.
- **Other keys.** Keys 7 and 9, and key 8 with any other `compareType`, do not modify the buffer.
- **`validLength`** = ~`ovf` & (`MIN_LEN` ≤ `entry_len` ≤ `MAX_LEN`).
- **`validLengthPC`** = ~`ovf` & (`entry_len` == `PC_LEN`).
- **`correct_input`** by `compareType`:
  - COMPAREPC: `entry` == `PC_CODE` & `entry_len` == `PC_LEN` & ~`ovf`.
  - COMPAREUC: `entry` == `uc` & `entry_len` == `uc_len` & ~`ovf`.
  - MATCHUC: `entry` == `cand` & `entry_len` == `cand_len` & ~`ovf` & ~`cand_ovf` & `cand_len` ≥ `MIN_LEN`.
  - STOREUC: 0.
- **Full-vector comparison is correct** because unused slots are always 0.
- **Commit.** On each cycle with `store` = 1 and ~`cand_ovf` and `cand_len` ≥ `MIN_LEN`: `uc` ← `cand`, `uc_len` ← `cand_len`. This is idempotent while `store` is held. With an invalid candidate, `store` has no effect.
- **Simultaneous events.**
  - A `read_input` rise in the same cycle as a digit press: the clear wins and the digit is dropped.
  - `store` in the same cycle as a STOREUC key-8 capture: not reachable. The `cand` write wins and `uc` takes the old `cand`.

## Timing
- **Reset values:**
  - `entry` 0, `entry_len` 0, `ovf` 0.
  - `cand` 0, `cand_len` 0, `cand_ovf` 1.
  - `uc` = `UC_DEFAULT`, `uc_len` = `UC_DEFAULT_LEN`.
  - `prev_bstate` 0, registered `read_input` copy 0, `data_ready` 0.
  - Resulting outputs: `correct_input` 0 (COMPAREPC with an empty entry), `validLength` 0, `validLengthPC` 0, `entry_len` 0.
- **Digit latency.** A digit pressed in cycle N is visible in `entry`, `entry_len` and the length flags from cycle N+1.
- **Enter-key cycle.** `validLength` and `validLengthPC` during the command-key `press` cycle reflect only the digits entered before it. `controller` samples them in that cycle.
- **`data_ready`.** Registered `~read_input`: high from the first cycle after `read_input` falls, low from the cycle after it rises.
- **`correct_input`.** Valid in the cycle `controller` first enters a check state. No extra latency.
- **Reset mid-entry.** Aborts the entry and restores the default UC. Any uncommitted candidate is lost.

## Test plan
1. **PC accepted.** Reset, `read_input` 0→1, press 1,2,3,4,5,6, `compareType`=00, drop `read_input` → `validLengthPC`=1, `correct_input`=1, `data_ready`=1 one cycle after the fall.
2. **Default UC check.** Enter 1,2,3,4 with `compareType`=01 → `validLength`=1, `correct_input`=1. Enter 1,2,3 → `validLength`=0, `correct_input`=0.
3. **Overflow.** Press nine digits → `entry_len`=8, `ovf`=1, `validLength`=0, `correct_input`=0 for every `compareType`.
4. **Reprogram flow.**
   - STOREUC: enter 6,5,4,3,2, press 8 → `entry_len`=0.
   - MATCHUC: enter 6,5,4,3,2 → `correct_input`=1.
   - Pulse `store` for 5 cycles. A later COMPAREUC with 6,5,4,3,2 → 1; with 1,2,3,4 → 0.
5. **Mismatched confirmation.** Confirm with 6,5,4,3,1 → `correct_input`=0. `store` with `cand_len`=3 (invalid) → UC unchanged.
6. **Masking and reset.** Presses with `read_input`=0, and `button`=12 during entry → buffer unchanged. Assert `reset` mid-entry → all reset values, and UC 1,2,3,4 is accepted again.
